axis_radix2_divider: RTL and testbench
======================================

// Module: axis_radix2_divider
// PURPOSE
//  Native iterative unsigned divider: the responder side of the AXI-Stream divisor/dividend/dout
//  interface that the EX-stage divide unit drives. Drop-in replacement for the vendor divider core.
//  Accepts both operand channels independently, runs a fixed-latency restoring radix-2 loop
//  (one quotient bit per clock) and returns {quotient, remainder} on a one-cycle result pulse.
//  Sign handling stays in the caller; this block is unsigned only.
// PARAMETERS
//  WIDTH  32  operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk                     in   1        rising-edge clock
//  sclr                    in   1        synchronous reset, active-high
//  s_axis_divisor_tvalid   in   1        divisor valid
//  s_axis_divisor_tready   out  1        divisor accepted when valid&ready at clk edge
//  s_axis_divisor_tdata    in   WIDTH    divisor (D)
//  s_axis_dividend_tvalid  in   1        dividend valid
//  s_axis_dividend_tready  out  1        dividend accepted when valid&ready at clk edge
//  s_axis_dividend_tdata   in   WIDTH    dividend (N)
//  m_axis_dout_tvalid      out  1        one-cycle result strobe, no backpressure
//  m_axis_dout_tdata       out  2*WIDTH  [2W-1:W]=quotient, [W-1:0]=remainder
// BEHAVIOUR
//  - Reset (sclr=1 at edge): state=IDLE, both capture flags clear, iteration counter 0,
//    m_axis_dout_tvalid=0, m_axis_dout_tdata=0. Both treadys are forced to 0 while sclr=1.
//  - States:
//      IDLE: collect operands.
//      BUSY: WIDTH iterations.
//      DONE: one cycle, result strobe.
//  - IDLE: each channel's tready=1 until that channel is captured, then 0.
//    Captures are independent: either order, any gap, or the same cycle.
//    A captured operand is held. A second valid on an already-captured channel is ignored (not acked).
//  - Transition IDLE->BUSY at the edge where the second operand is captured (cycle N).
//    Edge-ending cycle N loads: remainder reg=0, quotient/shift reg=N, divisor reg=D, counter=0.
//  - BUSY (cycles N+1..N+WIDTH): per edge, {r,q} shift left 1; trial = r - D (WIDTH+1 bits).
//    If trial is non-negative, r=trial and q[0]=1; else q[0]=0. Counter increments.
//    Leave BUSY at the edge where counter==WIDTH-1.
//  - DONE: m_axis_dout_tvalid=1 exactly in cycle N+WIDTH+1 (fixed latency, data-independent).
//    tdata is registered and valid in that cycle. Next edge: tvalid->0, state->IDLE, flags clear.
//  - tdata holds the last result after the strobe until the next DONE or reset.
//  - Both treadys are 0 in BUSY and DONE; the earliest next acceptance is cycle N+WIDTH+2.
//  - Divide by zero: no special path. The loop yields quotient=all-ones, remainder=dividend,
//    same latency, no error flag.
//  - Reset mid-operation: an in-flight division is discarded. No tvalid is produced for it.
//    Captured operands are dropped.
//  - No tready on dout: the consumer must sample in the strobe cycle.
// TESTING
//  1. Divisor=7 and dividend=100, both valid in cycle 0 -> both treadys high in cycle 0;
//     tvalid only in cycle 33; tdata=0x0000000E_00000002.
//  2. Divisor valid in cycle 0, dividend valid in cycle 3 (N=3), 0xFFFFFFFF/1 ->
//     divisor tready=0 in cycles 1-3; tvalid in cycle 36; tdata=0xFFFFFFFF_00000000.
//  3. 0x12345678/0 -> tvalid at N+33; tdata=0xFFFFFFFF_12345678.
//  4. 5/9 -> quotient 0, remainder 5 (0x00000000_00000005).
//     0x80000000/0x80000000 -> 0x00000001_00000000.
//  5. Both channels held valid continuously with new operands 50/5 -> treadys low in N+1..N+33;
//     second pair accepted in cycle N+34; second tvalid in N+67 with 0x0000000A_00000000.
//  6. sclr=1 during BUSY at iteration 10 -> no tvalid ever for that job; tdata=0.
//     Treadys high the first cycle after sclr drops; a fresh 9/3 completes with 0x00000003_00000000.

Source files
------------

// File: rtl/axis_radix2_divider.sv
`default_nettype none
// ============================================================================
// Module   : axis_radix2_divider
// Brief    : AXI-Stream unsigned restoring radix-2 divider, one quotient bit
//            per clock, fixed WIDTH+1 cycle latency after the last operand.
// Revision : 1.0 - initial release
// ============================================================================
module axis_radix2_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               sclr,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_div_cap;
    logic                 r_dvd_cap;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dsr;
    logic                 r_dout_valid;
    logic [2*WIDTH-1:0]   r_dout_data;

    logic                 w_div_fire;
    logic                 w_dvd_fire;
    logic                 w_both_held;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    assign s_axis_divisor_tready  = (r_state == S_IDLE) && !r_div_cap && !sclr;
    assign s_axis_dividend_tready = (r_state == S_IDLE) && !r_dvd_cap && !sclr;

    assign w_div_fire  = s_axis_divisor_tvalid  && s_axis_divisor_tready;
    assign w_dvd_fire  = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign w_both_held = (r_div_cap || w_div_fire) && (r_dvd_cap || w_dvd_fire);

    // Partial remainder gains the next dividend bit; sign of the trial decides the quotient bit.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dsr};
    assign w_ge       = (w_shift >= {1'b0, r_dsr});
    assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_both_held) w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == c_last_iter) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_div_cap    <= 1'b0;
            r_dvd_cap    <= 1'b0;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dsr        <= '0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Operands land directly in the working registers and are held there.
                    if (w_div_fire) begin
                        r_dsr     <= s_axis_divisor_tdata;
                        r_div_cap <= 1'b1;
                    end
                    if (w_dvd_fire) begin
                        r_quo     <= s_axis_dividend_tdata;
                        r_dvd_cap <= 1'b1;
                    end
                    if (w_both_held) begin
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_dout_valid <= 1'b1;
                        r_dout_data  <= {w_quo_next, w_rem_next};
                    end
                end
                S_DONE: begin
                    r_div_cap <= 1'b0;
                    r_dvd_cap <= 1'b0;
                end
                default: begin
                    r_div_cap <= 1'b0;
                    r_dvd_cap <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_dout_tvalid = r_dout_valid;
    assign m_axis_dout_tdata  = r_dout_data;

endmodule
`default_nettype wire

// File: tb/tb_axis_radix2_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_radix2_divider
// Brief    : Self-checking bench for axis_radix2_divider (directed + random jobs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_radix2_divider;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               sclr = 1'b1;
    logic               div_v = 1'b0;
    logic               div_r;
    logic [WIDTH-1:0]   div_d = '0;
    logic               dvd_v = 1'b0;
    logic               dvd_r;
    logic [WIDTH-1:0]   dvd_d = '0;
    logic               tv;
    logic [2*WIDTH-1:0] td;

    int n_checks = 0;
    int n_fail   = 0;

    axis_radix2_divider #(.WIDTH(WIDTH)) u_dut (
        .clk                    (clk),
        .sclr                   (sclr),
        .s_axis_divisor_tvalid  (div_v),
        .s_axis_divisor_tready  (div_r),
        .s_axis_divisor_tdata   (div_d),
        .s_axis_dividend_tvalid (dvd_v),
        .s_axis_dividend_tready (dvd_r),
        .s_axis_dividend_tdata  (dvd_d),
        .m_axis_dout_tvalid     (tv),
        .m_axis_dout_tdata      (td)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Quotient/remainder straight from integer arithmetic; divide by zero gives all-ones/N.
    function automatic logic [63:0] ref_div(input logic [31:0] n, input logic [31:0] d);
        if (d == 32'd0) return {32'hFFFF_FFFF, n};
        return {n / d, n % d};
    endfunction

    // Entered right after a rising edge; returns at the falling edge of the capture cycle.
    task automatic send(input logic [31:0] d, input logic [31:0] n,
                        input int dd, input int nd, output int ncap);
        bit dgot = 1'b0;
        bit ngot = 1'b0;
        int bad  = 0;
        ncap = -1;
        for (int c = 0; c < 100; c++) begin
            div_v = (c >= dd) && !dgot;
            div_d = d;
            dvd_v = (c >= nd) && !ngot;
            dvd_d = n;
            @(negedge clk);
            if (dgot && div_r) bad++;
            if (ngot && dvd_r) bad++;
            if (div_v && div_r) dgot = 1'b1;
            if (dvd_v && dvd_r) ngot = 1'b1;
            if (dgot && ngot) begin
                ncap = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("cap_cycle", 64'(ncap), 64'((dd > nd) ? dd : nd));
        check("cap_ready_drop", 64'(bad), 64'd0);
    endtask

    // Watches cycles N+1..N+34; with hold set the valids stay high carrying new operands.
    task automatic wait_result(input logic [63:0] exp, input bit hold,
                               input logic [31:0] hd, input logic [31:0] hn, input string tag);
        int first = -1;
        int ntv   = 0;
        int bad   = 0;
        logic [63:0] got = '0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if (hold) begin
                    div_d = hd;
                    dvd_d = hn;
                end else begin
                    div_v = 1'b0;
                    dvd_v = 1'b0;
                end
            end
            @(negedge clk);
            if (tv) begin
                ntv++;
                if (first < 0) begin
                    first = k;
                    got   = td;
                end
            end
            if (k <= 33 && (div_r || dvd_r)) bad++;
        end
        check({tag, "_latency"}, 64'(first), 64'd33);
        check({tag, "_strobes"}, 64'(ntv), 64'd1);
        check({tag, "_data"}, got, exp);
        check({tag, "_data_hold"}, td, exp);
        check({tag, "_busy_ready"}, 64'(bad), 64'd0);
        check({tag, "_ready_again"}, 64'({div_r, dvd_r}), 64'd3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nc;
        int ntv;
        logic [31:0] rd, rn;

        sclr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(tv), 64'd0);
        check("rst_tdata", td, 64'd0);
        check("rst_ready", 64'({div_r, dvd_r}), 64'd0);
        @(posedge clk); #1;
        sclr = 1'b0;

        send(32'd7, 32'd100, 0, 0, nc);
        wait_result(64'h0000000E_00000002, 1'b0, '0, '0, "t1");
        @(posedge clk); #1;

        send(32'd1, 32'hFFFF_FFFF, 0, 3, nc);
        wait_result(64'hFFFFFFFF_00000000, 1'b0, '0, '0, "t2");
        @(posedge clk); #1;

        send(32'd0, 32'h1234_5678, 2, 0, nc);
        wait_result(64'hFFFFFFFF_12345678, 1'b0, '0, '0, "t3");
        @(posedge clk); #1;

        send(32'd9, 32'd5, 1, 1, nc);
        wait_result(64'h00000000_00000005, 1'b0, '0, '0, "t4a");
        @(posedge clk); #1;

        send(32'h8000_0000, 32'h8000_0000, 0, 0, nc);
        wait_result(64'h00000001_00000000, 1'b0, '0, '0, "t4b");
        @(posedge clk); #1;

        // Back-to-back jobs with both valids never dropping.
        send(32'd7, 32'd80, 0, 0, nc);
        wait_result(64'h0000000B_00000003, 1'b1, 32'd5, 32'd50, "t5a");
        wait_result(64'h0000000A_00000000, 1'b0, '0, '0, "t5b");
        @(posedge clk); #1;

        // Reset in the middle of an iteration loop.
        send(32'd3, 32'd99999, 0, 0, nc);
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                div_v = 1'b0;
                dvd_v = 1'b0;
            end
        end
        @(posedge clk); #1;
        sclr = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", 64'({div_r, dvd_r}), 64'd0);
        @(posedge clk); #1;
        sclr = 1'b0;
        @(negedge clk);
        check("t6_ready_after", 64'({div_r, dvd_r}), 64'd3);
        check("t6_tdata", td, 64'd0);
        ntv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tv) ntv++;
        end
        check("t6_no_strobe", 64'(ntv), 64'd0);
        @(posedge clk); #1;
        send(32'd3, 32'd9, 0, 0, nc);
        wait_result(64'h00000003_00000000, 1'b0, '0, '0, "t6");
        @(posedge clk); #1;

        for (int j = 0; j < 12; j++) begin
            rd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
            rn = $urandom();
            if (j % 4 == 1) rn = rn >> $urandom_range(0, 31);
            send(rd, rn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), nc);
            wait_result(ref_div(rn, rd), 1'b0, '0, '0, "rand");
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
